mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache fills, D-cache fills and D write-throughs
// onto a single memory port. Fills are 8 half-word reads of a 16-byte block.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    output logic        fill_wen,
    output logic [2:0]  fill_idx,
    output logic [15:0] fill_data,
    output logic        fill_sel_d,
    output logic        i_done,
    output logic        d_done,
    output logic        busy
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 12;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LAST_WORD = CW'(7);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t        state;
    logic [BW-1:0] blk;
    logic          sel_d;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] iss_cnt;
    logic          iss_done;
    logic [CW-1:0] rcv_cnt;

    // Byte offset of an I-miss address is irrelevant: fills are whole blocks.
    logic unused_i_lsbs;
    assign unused_i_lsbs = ^i_addr[3:0];

    // Arbitration, request latching and fill/write sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            blk      <= '0;
            sel_d    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            iss_cnt  <= '0;
            iss_done <= 1'b0;
            rcv_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    iss_cnt  <= '0;
                    iss_done <= 1'b0;
                    rcv_cnt  <= '0;
                    if (d_wr) begin
                        state   <= WRITE;
                        sel_d   <= 1'b1;
                        wr_addr <= d_addr;
                        wr_data <= d_wdata;
                    end else if (d_req) begin
                        state <= FILL;
                        sel_d <= 1'b1;
                        blk   <= d_addr[15:4];
                    end else if (i_req) begin
                        state <= FILL;
                        sel_d <= 1'b0;
                        blk   <= i_addr[15:4];
                    end
                end
                FILL: begin
                    // Issue side stops at word 7 via a flag so the counter never wraps.
                    if (!iss_done) begin
                        if (iss_cnt == LAST_WORD) begin
                            iss_done <= 1'b1;
                        end else begin
                            iss_cnt <= iss_cnt + CW'(1);
                        end
                    end
                    // Completion is counted purely on returned words, not on latency.
                    if (mem_valid) begin
                        if (rcv_cnt == LAST_WORD) begin
                            state <= IDLE;
                        end else begin
                            rcv_cnt <= rcv_cnt + CW'(1);
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode; fill port and done pulses follow mem_valid in the same cycle.
    always_comb begin
        mem_addr   = '0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        fill_wen   = 1'b0;
        fill_idx   = '0;
        fill_data  = '0;
        fill_sel_d = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            FILL: begin
                fill_sel_d = sel_d;
                if (!iss_done) begin
                    mem_en   = 1'b1;
                    mem_addr = {blk, iss_cnt, 1'b0};
                end
                if (mem_valid) begin
                    fill_wen  = 1'b1;
                    fill_idx  = rcv_cnt;
                    fill_data = mem_rdata;
                    if (rcv_cnt == LAST_WORD) begin
                        d_done = sel_d;
                        i_done = !sel_d;
                    end
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                d_done    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized transactions against a
// transaction-level model of the arbiter and a latency-based memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_wr;
    logic [15:0] d_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic        fill_wen;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        fill_sel_d;
    logic        i_done;
    logic        d_done;
    logic        busy;

    int compared = 0;
    int mism = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .fill_wen(fill_wen), .fill_idx(fill_idx), .fill_data(fill_data),
        .fill_sel_d(fill_sel_d), .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of the word address.
    function automatic logic [15:0] rdf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Memory model: reads issued in cycle c return in cycle c+4, spaced by 'gap' idle cycles.
    typedef struct {
        logic [15:0] a;
        int          due;
    } rd_t;
    rd_t pend[$];
    int  cyc = 0;
    int  last_del = -100;
    int  gap = 0;

    always @(negedge clk) begin
        if (mem_en === 1'b1 && mem_wr === 1'b0) pend.push_back('{mem_addr, cyc + 4});
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc && (cyc - last_del) > gap) begin
            mem_valid = 1'b1;
            mem_rdata = rdf(pend[0].a);
            void'(pend.pop_front());
            last_del = cyc;
        end else begin
            mem_valid = 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All outputs quiet: used for IDLE cycles and cycles after reset.
    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, 16'(busy), 16'h0);
        chk({tag, ".mem_en"}, 16'(mem_en), 16'h0);
        chk({tag, ".mem_wr"}, 16'(mem_wr), 16'h0);
        chk({tag, ".mem_addr"}, mem_addr, 16'h0);
        chk({tag, ".mem_wdata"}, mem_wdata, 16'h0);
        chk({tag, ".fill_wen"}, 16'(fill_wen), 16'h0);
        chk({tag, ".fill_idx"}, 16'(fill_idx), 16'h0);
        chk({tag, ".fill_data"}, fill_data, 16'h0);
        chk({tag, ".fill_sel_d"}, 16'(fill_sel_d), 16'h0);
        chk({tag, ".i_done"}, 16'(i_done), 16'h0);
        chk({tag, ".d_done"}, 16'(d_done), 16'h0);
    endtask

    // Expected fill: grant on the next edge, 8 reads of block a on consecutive
    // cycles, one fill word per returned read in order, done with the 8th word.
    task automatic expect_fill(input bit is_d, input logic [15:0] a, input bit drop, output int ncyc);
        int          issued;
        int          got;
        logic [11:0] blk;
        logic [2:0]  ii;
        logic [2:0]  gi;
        logic        en_e;
        issued = 0;
        got    = 0;
        blk    = a[15:4];
        ncyc   = 0;
        @(posedge clk);
        while (got < 8 && ncyc < 80) begin
            @(negedge clk);
            ncyc++;
            ii   = 3'(issued);
            gi   = 3'(got);
            en_e = (issued < 8);
            chk("fill.busy", 16'(busy), 16'h1);
            chk("fill.mem_en", 16'(mem_en), 16'(en_e));
            chk("fill.mem_addr", mem_addr, en_e ? {blk, ii, 1'b0} : 16'h0);
            chk("fill.mem_wr", 16'(mem_wr), 16'h0);
            chk("fill.mem_wdata", mem_wdata, 16'h0);
            chk("fill.sel_d", 16'(fill_sel_d), 16'(is_d));
            chk("fill.wen", 16'(fill_wen), 16'(mem_valid));
            chk("fill.idx", 16'(fill_idx), mem_valid ? 16'(gi) : 16'h0);
            chk("fill.data", fill_data, mem_valid ? rdf({blk, gi, 1'b0}) : 16'h0);
            chk("fill.d_done", 16'(d_done), 16'(is_d && mem_valid && got == 7));
            chk("fill.i_done", 16'(i_done), 16'(!is_d && mem_valid && got == 7));
            // Inputs of the granted requester change after grant and must be ignored.
            if (ncyc == 1) begin
                if (is_d) begin
                    d_addr  = 16'($urandom);
                    d_wdata = 16'($urandom);
                end else begin
                    i_addr = 16'($urandom);
                end
            end
            if (drop && ncyc == 4) begin
                if (is_d) d_req = 1'b0;
                else i_req = 1'b0;
            end
            if (issued < 8) issued++;
            if (mem_valid) got++;
        end
        chk("fill.words", 16'(got), 16'd8);
    endtask

    // Expected write-through: one cycle with the latched address/data and d_done.
    task automatic expect_write(input logic [15:0] a, input logic [15:0] w);
        @(posedge clk);
        @(negedge clk);
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
        chk("wr.busy", 16'(busy), 16'h1);
        chk("wr.mem_en", 16'(mem_en), 16'h1);
        chk("wr.mem_wr", 16'(mem_wr), 16'h1);
        chk("wr.mem_addr", mem_addr, a);
        chk("wr.mem_wdata", mem_wdata, w);
        chk("wr.d_done", 16'(d_done), 16'h1);
        chk("wr.i_done", 16'(i_done), 16'h0);
        chk("wr.fill_wen", 16'(fill_wen), 16'h0);
        chk("wr.fill_sel_d", 16'(fill_sel_d), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          got;
        int          k;
        int          stray;
        int          kind;
        logic [15:0] a;
        logic [15:0] w;

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle0");

        // D fill of 0x1234 with fixed 4-cycle memory: 12 busy cycles.
        d_req = 1'b1; d_addr = 16'h1234;
        expect_fill(1'b1, 16'h1234, 1'b0, n);
        chk("d_fill.busy_cycles", 16'(n), 16'd12);
        d_req = 1'b0;
        @(negedge clk);
        chk_idle("d_fill.after");

        // Simultaneous I and D: D first, one IDLE cycle, then I.
        a = 16'($urandom); w = 16'($urandom);
        d_req = 1'b1; d_addr = a; i_req = 1'b1; i_addr = w;
        expect_fill(1'b1, a, 1'b0, n);
        d_req = 1'b0;
        @(negedge clk);
        chk_idle("both.gap");
        expect_fill(1'b0, w, 1'b0, n);
        i_req = 1'b0;
        @(negedge clk);
        chk_idle("both.after");

        // Write-through.
        d_wr = 1'b1; d_addr = 16'h00A4; d_wdata = 16'hBEEF;
        expect_write(16'h00A4, 16'hBEEF);
        d_wr = 1'b0;
        @(negedge clk);
        chk_idle("wr.after");

        // I request during a D fill, i_addr changes before the I grant.
        d_req = 1'b1; d_addr = 16'h4560;
        fork
            expect_fill(1'b1, 16'h4560, 1'b0, n);
            begin
                repeat (3) @(negedge clk);
                i_req = 1'b1; i_addr = 16'h7770;
                repeat (3) @(negedge clk);
                i_addr = 16'h9994;
            end
        join
        d_req = 1'b0;
        @(negedge clk);
        chk_idle("late_i.gap");
        expect_fill(1'b0, 16'h9994, 1'b0, n);
        i_req = 1'b0;
        @(negedge clk);
        chk_idle("late_i.after");

        // Requester drops mid-fill; fill and done still happen.
        i_req = 1'b1; i_addr = 16'hCAFE;
        expect_fill(1'b0, 16'hCAFE, 1'b1, n);
        @(negedge clk);
        chk_idle("drop.after");

        // Slow memory: 2 idle cycles between returned words.
        gap = 2;
        d_req = 1'b1; d_addr = 16'h5A5A;
        expect_fill(1'b1, 16'h5A5A, 1'b0, n);
        d_req = 1'b0;
        gap = 0;
        @(negedge clk);
        chk_idle("gap.after");

        // Reset after 3 fill words: abort, stray returns ignored, restart at idx 0.
        d_req = 1'b1; d_addr = 16'h3C40;
        @(posedge clk);
        got = 0; k = 0;
        while (got < 3 && k < 40) begin
            @(negedge clk);
            k++;
            if (fill_wen) begin
                chk("rst.pre_idx", 16'(fill_idx), 16'(got));
                got++;
            end
        end
        chk("rst.pre_words", 16'(got), 16'd3);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk_idle("rst.abort");
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_valid) stray++;
            chk("rst.stray_wen", 16'(fill_wen), 16'h0);
            chk("rst.stray_done", 16'({i_done, d_done}), 16'h0);
            chk("rst.stray_busy", 16'(busy), 16'h0);
        end
        chk("rst.stray_seen", 16'(stray > 0), 16'h1);
        d_req = 1'b1; d_addr = 16'h3C40;
        expect_fill(1'b1, 16'h3C40, 1'b0, n);
        d_req = 1'b0;
        @(negedge clk);
        chk_idle("rst.refill_after");

        // Request held through reset is granted on the first edge after release.
        rst = 1'b1; i_req = 1'b1; i_addr = 16'h0F10;
        @(negedge clk);
        rst = 1'b0;
        expect_fill(1'b0, 16'h0F10, 1'b0, n);
        i_req = 1'b0;
        @(negedge clk);
        chk_idle("rst_grant.after");

        // Random mix of transactions, memory spacing and mid-fill drops.
        for (int t = 0; t < 12; t++) begin
            kind = int'($urandom_range(0, 2));
            gap  = int'($urandom_range(0, 2));
            a    = 16'($urandom);
            w    = 16'($urandom);
            if (kind == 0) begin
                d_wr = 1'b1; d_addr = a; d_wdata = w;
                expect_write(a, w);
            end else if (kind == 1) begin
                d_req = 1'b1; d_addr = a;
                expect_fill(1'b1, a, $urandom_range(0, 1) == 1, n);
            end else begin
                i_req = 1'b1; i_addr = a;
                expect_fill(1'b0, a, $urandom_range(0, 1) == 1, n);
            end
            d_wr = 1'b0; d_req = 1'b0; i_req = 1'b0;
            @(negedge clk);
            chk_idle("rand.after");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
